// File: rtl/regfile_write_arbiter.sv
// Two-requester round-robin arbiter for a register file write port.
// Supports locked bursts with an idle timeout and a registered write strobe.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 1,
    parameter int LOCK_TIMEOUT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req0_lock,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    input  logic                  req1_lock,
    output logic                  req1_ready,
    output logic                  rf_write_enable,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    output logic                  last_grant,
    output logic                  locked
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    localparam logic [7:0] CntLast = 8'(LOCK_TIMEOUT - 1);

    state_e                state_q, state_d;
    logic [7:0]            idle_cnt_q, idle_cnt_d;
    logic                  last_grant_q;
    logic                  locked_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  ready0, ready1;
    logic                  xfer;
    logic                  xfer_lock;

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        ready0     = 1'b0;
        ready1     = 1'b0;
        xfer       = 1'b0;
        xfer_lock  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Tie goes to the requester that did not win last time
                ready0 = req0_valid && (!req1_valid || last_grant_q);
                ready1 = req1_valid && (!req0_valid || !last_grant_q);
            end
            OWN0: begin
                ready0 = req0_valid;
                if (!req0_valid) begin
                    if (idle_cnt_q >= CntLast) begin
                        state_d    = IDLE;
                        idle_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 8'd1;
                    end
                end
            end
            OWN1: begin
                ready1 = req1_valid;
                if (!req1_valid) begin
                    if (idle_cnt_q >= CntLast) begin
                        state_d    = IDLE;
                        idle_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                idle_cnt_d = '0;
            end
        endcase
        if (reset) begin
            ready0 = 1'b0;
            ready1 = 1'b0;
        end
        xfer      = ready0 || ready1;
        xfer_lock = ready1 ? req1_lock : req0_lock;
        if (xfer) begin
            idle_cnt_d = '0;
            if (xfer_lock) begin
                state_d = ready1 ? OWN1 : OWN0;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            idle_cnt_q   <= '0;
            last_grant_q <= 1'b1;
            locked_q     <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            locked_q   <= (state_d != IDLE);
            we_q       <= xfer;
            if (xfer) begin
                last_grant_q <= ready1;
                addr_q       <= ready1 ? req1_addr : req0_addr;
                data_q       <= ready1 ? req1_data : req0_data;
            end
        end
    end

    assign req0_ready      = ready0;
    assign req1_ready      = ready1;
    assign rf_write_enable = we_q;
    assign rf_addr         = addr_q;
    assign rf_write_data   = data_q;
    assign last_grant      = last_grant_q;
    assign locked          = locked_q;

endmodule
